// File: rtl/bcd_field_counter.sv
`default_nettype none
// ============================================================================
// Module  : bcd_field_counter
// Brief   : One chainable BCD clock/calendar field with a runtime upper limit,
//           run/edit modes and press-and-hold auto-repeat.
// Revision: 1.0 - initial release
// ============================================================================
module bcd_field_counter #(
  parameter int DIGITS    = 2,
  parameter int MIN_VAL   = 1,
  parameter int MAX_VAL   = 31,
  parameter int BIN_W     = 7,
  parameter int RPT_DELAY = 8,
  parameter int RPT_RATE  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mode_run,
  input  logic                  tick_in,
  input  logic                  up,
  input  logic                  down,
  input  logic [BIN_W-1:0]      max_val,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic [BIN_W-1:0]      value_bin,
  output logic                  tick_out
);

  localparam int c_hold_w = (RPT_DELAY > 0) ? $clog2(RPT_DELAY + 1) : 1;
  localparam int c_rate_w = (RPT_RATE > 1) ? $clog2(RPT_RATE + 1) : 1;

  localparam logic [BIN_W-1:0]    c_min      = BIN_W'(MIN_VAL);
  localparam logic [BIN_W-1:0]    c_max      = BIN_W'(MAX_VAL);
  localparam logic [BIN_W-1:0]    c_one      = BIN_W'(1);
  localparam logic [c_hold_w-1:0] c_delay    = c_hold_w'(RPT_DELAY);
  localparam logic [c_hold_w-1:0] c_hold_one = c_hold_w'(1);
  localparam logic [c_rate_w-1:0] c_rate     = c_rate_w'(RPT_RATE);
  localparam logic [c_rate_w-1:0] c_rate_one = c_rate_w'(1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_HELD_UP = 2'd1,
    S_HELD_DN = 2'd2
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [c_hold_w-1:0]   r_hold_cnt, w_hold_nxt, w_hold_inc;
  logic [c_rate_w-1:0]   r_rate_cnt, w_rate_nxt, w_rate_inc;
  logic                  r_lock, w_lock_nxt;
  logic [BIN_W-1:0]      r_value, w_value_nxt, w_eff_max;
  logic [4*DIGITS-1:0]   r_bcd, w_bcd_nxt;
  logic                  r_tick, w_tick_nxt;
  logic                  w_step_up, w_step_dn, w_held, w_rpt;

  // Double-dabble; MAX_VAL < 10**DIGITS so nothing is lost off the top.
  function automatic logic [4*DIGITS-1:0] bin2bcd(input logic [BIN_W-1:0] b);
    logic [4*DIGITS-1:0] r;
    r = '0;
    for (int i = BIN_W - 1; i >= 0; i--) begin
      for (int d = 0; d < DIGITS; d++) begin
        if (r[4*d +: 4] >= 4'd5) r[4*d +: 4] = r[4*d +: 4] + 4'd3;
      end
      r = {r[4*DIGITS-2:0], b[i]};
    end
    return r;
  endfunction

  assign w_eff_max  = (max_val >= c_min && max_val <= c_max) ? max_val : c_max;
  assign w_hold_inc = r_hold_cnt + c_hold_one;
  assign w_rate_inc = r_rate_cnt + c_rate_one;

  // Button FSM. r_lock keeps a button held through reset from acting as a
  // fresh press until both buttons have been released once.
  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold_cnt;
    w_rate_nxt  = r_rate_cnt;
    w_step_up   = 1'b0;
    w_step_dn   = 1'b0;
    w_held      = 1'b0;
    w_rpt       = 1'b0;
    w_lock_nxt  = r_lock & (up | down);
    if (mode_run) begin
      w_state_nxt = S_IDLE;
      w_hold_nxt  = '0;
      w_rate_nxt  = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_hold_nxt = '0;
          w_rate_nxt = '0;
          if (!r_lock) begin
            if (up && !down) begin
              w_step_up   = 1'b1;
              w_state_nxt = S_HELD_UP;
            end else if (down && !up) begin
              w_step_dn   = 1'b1;
              w_state_nxt = S_HELD_DN;
            end
          end
        end
        S_HELD_UP, S_HELD_DN: begin
          w_held = (r_state == S_HELD_UP) ? (up && !down) : (down && !up);
          if (!w_held) begin
            w_state_nxt = S_IDLE;
            w_hold_nxt  = '0;
            w_rate_nxt  = '0;
          end else if (RPT_DELAY == 0) begin
            if (r_hold_cnt != '1) w_hold_nxt = w_hold_inc;
          end else if (r_hold_cnt < c_delay) begin
            w_hold_nxt = w_hold_inc;
            w_rpt      = (w_hold_inc == c_delay);
          end else if (w_rate_inc >= c_rate) begin
            w_rpt      = 1'b1;
            w_rate_nxt = '0;
          end else begin
            w_rate_nxt = w_rate_inc;
          end
          w_step_up = w_rpt && (r_state == S_HELD_UP);
          w_step_dn = w_rpt && (r_state == S_HELD_DN);
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_hold_nxt  = '0;
          w_rate_nxt  = '0;
        end
      endcase
    end
  end

  always_comb begin
    w_value_nxt = r_value;
    w_tick_nxt  = 1'b0;
    if (mode_run) begin
      if (tick_in) begin
        if (r_value >= w_eff_max) begin
          w_value_nxt = c_min;
          w_tick_nxt  = 1'b1;
        end else begin
          w_value_nxt = r_value + c_one;
        end
      end else if (r_value > w_eff_max) begin
        w_value_nxt = w_eff_max;
      end
    end else if (w_step_up) begin
      w_value_nxt = (r_value >= w_eff_max) ? c_min : r_value + c_one;
    end else if (w_step_dn) begin
      if (r_value > w_eff_max || r_value <= c_min) w_value_nxt = w_eff_max;
      else                                         w_value_nxt = r_value - c_one;
    end else if (r_value > w_eff_max) begin
      w_value_nxt = w_eff_max;
    end
  end

  assign w_bcd_nxt = bin2bcd(w_value_nxt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_hold_cnt <= '0;
      r_rate_cnt <= '0;
      r_lock     <= 1'b1;
      r_value    <= c_min;
      r_bcd      <= bin2bcd(c_min);
      r_tick     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_hold_cnt <= w_hold_nxt;
      r_rate_cnt <= w_rate_nxt;
      r_lock     <= w_lock_nxt;
      r_value    <= w_value_nxt;
      r_bcd      <= w_bcd_nxt;
      r_tick     <= w_tick_nxt;
    end
  end

  assign bcd_out   = r_bcd;
  assign value_bin = r_value;
  assign tick_out  = r_tick;

endmodule
`default_nettype wire
